// File: rtl/bus4_pkg.sv
// Shared definitions for chips on the 4-bit multiplexed CPU bus:
// subcycle encoding, I/O-group opcodes and SRC address fields.
package bus4_pkg;

   typedef enum logic [2:0] {
      SC_A1 = 3'd0,
      SC_A2 = 3'd1,
      SC_A3 = 3'd2,
      SC_M1 = 3'd3,
      SC_M2 = 3'd4,
      SC_X1 = 3'd5,
      SC_X2 = 3'd6,
      SC_X3 = 3'd7
   } subcycle_e;

   typedef enum logic [3:0] {
      OP_WRM = 4'h0,
      OP_WMP = 4'h1,
      OP_WRR = 4'h2,
      OP_WPM = 4'h3,
      OP_WR0 = 4'h4,
      OP_WR1 = 4'h5,
      OP_WR2 = 4'h6,
      OP_WR3 = 4'h7,
      OP_SBM = 4'h8,
      OP_RDM = 4'h9,
      OP_RDR = 4'hA,
      OP_ADM = 4'hB,
      OP_RD0 = 4'hC,
      OP_RD1 = 4'hD,
      OP_RD2 = 4'hE,
      OP_RD3 = 4'hF
   } io_op_e;

   localparam int SRC_CHIP_MSB = 3;
   localparam int SRC_CHIP_LSB = 2;
   localparam int SRC_REG_MSB  = 1;
   localparam int SRC_REG_LSB  = 0;

   // WR0-WR3 share the 01xx opcode row; the low bits pick the status nibble.
   function automatic logic is_status_wr(input io_op_e op);
      return (op[3:2] == 2'b01);
   endfunction

endpackage

// File: rtl/bus_timing.sv
// Subcycle counter for bus peers: free-runs A1..X3 and is forced back to A1
// by sync, so a late or early sync re-aligns the frame on the next edge.
module bus_timing
   import bus4_pkg::*;
(
   input  logic      i_clock,
   input  logic      i_reset,
   input  logic      i_sync,
   output subcycle_e o_subcycle
);

   subcycle_e r_cnt;

   // Subcycle counter, sync-aligned
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= SC_A1;
      end else if (i_sync) begin
         r_cnt <= SC_A1;
      end else begin
         r_cnt <= subcycle_e'(r_cnt + 3'd1);
      end
   end

   assign o_subcycle = r_cnt;

endmodule

// File: rtl/ram_4002.sv
// Data RAM / output port peer on the 4-bit CPU bus: selected by SRC, then
// services I/O opcodes qualified by cmd in M2, with data exchanged in X2.
module ram_4002
   import bus4_pkg::*;
#(
   parameter logic [1:0] CHIP_ID = 2'd0
) (
   input  logic       clock,
   input  logic       reset,
   inout  wire  [3:0] data,
   input  logic       sync,
   input  logic       cmd,
   output logic [3:0] out_port
);

   subcycle_e  w_subcycle;
   logic       w_is_m2;
   logic       w_is_x2;
   logic       w_is_x3;
   logic       w_src;
   logic       w_wr_main;
   logic       w_wr_stat;
   logic       w_wr_port;
   logic       w_rd_hit;
   logic [3:0] w_rd_val;
   logic       w_bus_en;

   logic       r_selected;
   logic       r_src_hit;
   logic       r_inst_active;
   logic [1:0] r_reg_sel;
   logic [3:0] r_char_sel;
   io_op_e     r_opcode;
   logic [3:0] r_out_port;
   logic [3:0] r_main   [0:3][0:15];
   logic [3:0] r_status [0:3][0:3];

   bus_timing u_timing (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_sync     (sync),
      .o_subcycle (w_subcycle)
   );

   assign w_is_m2   = (w_subcycle == SC_M2);
   assign w_is_x2   = (w_subcycle == SC_X2);
   assign w_is_x3   = (w_subcycle == SC_X3);
   // An active instruction owns its X2, so cmd there is never an SRC.
   assign w_src     = w_is_x2 && !cmd && !r_inst_active;
   assign w_wr_main = r_inst_active && w_is_x2 && (r_opcode == OP_WRM);
   assign w_wr_port = r_inst_active && w_is_x2 && (r_opcode == OP_WMP);
   assign w_wr_stat = r_inst_active && w_is_x2 && is_status_wr(r_opcode);

   // Selection, address latch and instruction tracking
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_selected    <= 1'b0;
         r_src_hit     <= 1'b0;
         r_inst_active <= 1'b0;
         r_reg_sel     <= 2'd0;
         r_char_sel    <= 4'h0;
         r_opcode      <= OP_WRM;
         r_out_port    <= 4'h0;
      end else begin
         r_src_hit <= 1'b0;
         if (w_src) begin
            if (data[SRC_CHIP_MSB:SRC_CHIP_LSB] == CHIP_ID) begin
               r_selected <= 1'b1;
               r_reg_sel  <= data[SRC_REG_MSB:SRC_REG_LSB];
               r_src_hit  <= 1'b1;
            end else begin
               r_selected <= 1'b0;
            end
         end
         if (w_is_x3 && r_src_hit) begin
            r_char_sel <= data;
         end
         if (w_is_m2 && !cmd && r_selected) begin
            r_opcode      <= io_op_e'(data);
            r_inst_active <= 1'b1;
         end else if (w_is_x3) begin
            r_inst_active <= 1'b0;
         end
         if (w_wr_port) begin
            r_out_port <= data;
         end
      end
   end

   // Main and status nibble storage
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
               r_main[r][c] <= 4'h0;
            end
            for (int s = 0; s < 4; s++) begin
               r_status[r][s] <= 4'h0;
            end
         end
      end else begin
         if (w_wr_main) begin
            r_main[r_reg_sel][r_char_sel] <= data;
         end
         if (w_wr_stat) begin
            r_status[r_reg_sel][r_opcode[1:0]] <= data;
         end
      end
   end

   // Read data select; ROM/CPU-owned opcodes leave the bus alone
   always_comb begin
      w_rd_val = 4'h0;
      w_rd_hit = 1'b0;
      case (r_opcode)
         OP_SBM, OP_RDM, OP_ADM: begin
            w_rd_val = r_main[r_reg_sel][r_char_sel];
            w_rd_hit = 1'b1;
         end
         OP_RD0, OP_RD1, OP_RD2, OP_RD3: begin
            w_rd_val = r_status[r_reg_sel][r_opcode[1:0]];
            w_rd_hit = 1'b1;
         end
         OP_WRR, OP_WPM, OP_RDR: begin
            w_rd_hit = 1'b0;
         end
         default: begin
            w_rd_hit = 1'b0;
         end
      endcase
   end

   assign w_bus_en = w_rd_hit && r_inst_active && w_is_x2 && !reset;
   assign data     = w_bus_en ? w_rd_val : 4'bzzzz;
   assign out_port = r_out_port;

endmodule
